shmem_arbiter: RTL and testbench

- Shared-memory responder for the SIMD processor array.
- Arbitrates read/write requests from NPROC processing elements using round-robin with per-transaction locking.
- Serves bus-wide reads (SIMD_W elements) and sized writes from a single element-addressed register array.
- Provides a host preload/readback port used by the issuer and testbenches.

---
 rtl/shmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_shmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shmem_arbiter.sv
// Shared-memory responder: round-robin arbiter with per-transaction lock over NPROC ports.
// Latency: grants and read data are combinational (0 cycles); writes land on the next i_clk edge.
// Backpressure: ungranted requests wait; host writes suppress all grants for that cycle.
// Optional macro SHMEM_OOR_ERR_EN adds sticky out-of-range reporting (o_oor_err, o_oor_id).
module shmem_arbiter #(
   parameter int NPROC  = 4,
   parameter int USIZE  = 16,
   parameter int SIMD_W = 5,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                             i_clk,
   input  logic                             i_rstn,
   input  logic [NPROC-1:0]                 i_req_rd,
   input  logic [NPROC-1:0]                 i_req_wr,
   input  logic [NPROC*ADDR_W-1:0]          i_addr,
   input  logic [NPROC*USIZE*SIMD_W-1:0]    i_wr_data,
   input  logic [NPROC*3-1:0]               i_wr_size,
   input  logic [NPROC-1:0]                 i_wr_en,
   output logic [NPROC-1:0]                 o_grant_rd,
   output logic [NPROC-1:0]                 o_grant_wr,
   output logic [USIZE*SIMD_W-1:0]          o_rd_data,
   input  logic                             i_host_we,
   input  logic [ADDR_W-1:0]                i_host_addr,
   input  logic [USIZE-1:0]                 i_host_wdata,
   output logic [USIZE-1:0]                 o_host_rdata
`ifdef SHMEM_OOR_ERR_EN
   ,
   output logic                             o_oor_err,
   output logic [$clog2(NPROC)-1:0]         o_oor_id
`endif
);

   localparam int              BUS_W   = USIZE * SIMD_W;
   localparam int              PW      = $clog2(NPROC);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]      SIMD_SZ = 3'(SIMD_W);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

   logic [USIZE-1:0] mem [DEPTH];

   logic             gnt_vld;
   logic             gnt_is_rd;
   logic [PW-1:0]    gnt_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [BUS_W-1:0] sel_data;
   logic [2:0]       sel_size_raw;
   logic [2:0]       sel_size;
   logic             wr_acc;

   // Next port index, wrapping modulo NPROC (NPROC need not be a power of two)
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
      if (int'(idx) == NPROC-1) return '0;
      return idx + PW'(1);
   endfunction

   // Choose the granted port: the owner while locked, else first requester from rr_ptr
   always_comb begin
      logic [PW-1:0] cand;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = rr_ptr_q;
      if (i_rstn && !i_host_we) begin
         if (state_q == ST_LOCKED) begin
            if (i_req_rd[owner_q] || i_req_wr[owner_q]) begin
               gnt_vld = 1'b1;
               gnt_idx = owner_q;
            end
         end else begin
            for (int i = 0; i < NPROC; i++) begin
               if (!gnt_vld && (i_req_rd[cand] || i_req_wr[cand])) begin
                  gnt_vld = 1'b1;
                  gnt_idx = cand;
               end
               cand = wrap_inc(cand);
            end
         end
      end
   end

   // Read wins when a port raises both request types
   assign gnt_is_rd    = i_req_rd[gnt_idx];
   assign o_grant_rd   = (gnt_vld && gnt_is_rd)  ? (NPROC'(1) << gnt_idx) : '0;
   assign o_grant_wr   = (gnt_vld && !gnt_is_rd) ? (NPROC'(1) << gnt_idx) : '0;

   assign sel_addr     = i_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_data     = i_wr_data[int'(gnt_idx)*BUS_W +: BUS_W];
   assign sel_size_raw = i_wr_size[int'(gnt_idx)*3 +: 3];
   assign sel_size     = (sel_size_raw > SIMD_SZ) ? SIMD_SZ : sel_size_raw;
   assign wr_acc       = gnt_vld && !gnt_is_rd && i_wr_en[gnt_idx];

   // Bus-wide asynchronous read, MSB-first; elements past the end read as zero
   always_comb begin
      logic [ADDR_W:0] ea;
      o_rd_data = '0;
      ea        = '0;
      for (int k = 0; k < SIMD_W; k++) begin
         ea = {1'b0, sel_addr} + (ADDR_W+1)'(k);
         if (gnt_vld && gnt_is_rd && (ea < DEPTH_X)) begin
            o_rd_data[BUS_W-1-k*USIZE -: USIZE] = mem[ea[ADDR_W-1:0]];
         end
      end
   end

   assign o_host_rdata = ({1'b0, i_host_addr} < DEPTH_X) ? mem[i_host_addr] : '0;

   // Memory array: host element writes and granted sized bus writes (contents never reset)
   always_ff @(posedge i_clk) begin
      if (i_host_we) begin
         if ({1'b0, i_host_addr} < DEPTH_X) begin
            mem[i_host_addr] <= i_host_wdata;
         end
      end else if (wr_acc) begin
         for (int k = 0; k < SIMD_W; k++) begin
            if ((3'(k) < sel_size) && (({1'b0, sel_addr} + (ADDR_W+1)'(k)) < DEPTH_X)) begin
               mem[sel_addr + ADDR_W'(k)] <= sel_data[BUS_W-1-k*USIZE -: USIZE];
            end
         end
      end
   end

   // Lock bookkeeping: lock on grant, release on accepted write or idle owner; host cycles freeze it
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (!i_host_we) begin
         if (gnt_vld) begin
            owner_d = gnt_idx;
            if (wr_acc) begin
               state_d  = ST_OPEN;
               rr_ptr_d = wrap_inc(gnt_idx);
            end else begin
               state_d  = ST_LOCKED;
            end
         end else if (state_q == ST_LOCKED) begin
            state_d  = ST_OPEN;
            rr_ptr_d = wrap_inc(owner_q);
         end
      end
   end

   // Arbiter state registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= ST_OPEN;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef SHMEM_OOR_ERR_EN
   logic          oor_err_q, oor_err_d;
   logic [PW-1:0] oor_id_q, oor_id_d;
   logic          rd_oor;
   logic          wr_oor;

   assign rd_oor = gnt_vld && gnt_is_rd &&
                   (({1'b0, sel_addr} + (ADDR_W+1)'(SIMD_W)) > DEPTH_X);
   assign wr_oor = wr_acc &&
                   (({1'b0, sel_addr} + (ADDR_W+1)'(sel_size)) > DEPTH_X);

   // Sticky error flag; the id of the first offender is kept until reset
   always_comb begin
      oor_err_d = oor_err_q;
      oor_id_d  = oor_id_q;
      if (!oor_err_q && (rd_oor || wr_oor)) begin
         oor_err_d = 1'b1;
         oor_id_d  = gnt_idx;
      end
   end

   // Error registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         oor_err_q <= 1'b0;
         oor_id_q  <= '0;
      end else begin
         oor_err_q <= oor_err_d;
         oor_id_q  <= oor_id_d;
      end
   end

   assign o_oor_err = oor_err_q;
   assign o_oor_id  = oor_id_q;
`endif

endmodule

// File: tb/tb_shmem_arbiter.sv
// Bench for shmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled before the next edge.
// The model keeps its own memory image, current owner (-1 = none) and round-robin start.
module tb_shmem_arbiter;

   localparam int NPROC  = 4;
   localparam int USIZE  = 16;
   localparam int SIMD_W = 5;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int BUS_W  = USIZE * SIMD_W;

   logic                          i_clk = 1'b0;
   logic                          i_rstn;
   logic [NPROC-1:0]              i_req_rd;
   logic [NPROC-1:0]              i_req_wr;
   logic [NPROC*ADDR_W-1:0]       i_addr;
   logic [NPROC*BUS_W-1:0]        i_wr_data;
   logic [NPROC*3-1:0]            i_wr_size;
   logic [NPROC-1:0]              i_wr_en;
   logic [NPROC-1:0]              o_grant_rd;
   logic [NPROC-1:0]              o_grant_wr;
   logic [BUS_W-1:0]              o_rd_data;
   logic                          i_host_we;
   logic [ADDR_W-1:0]             i_host_addr;
   logic [USIZE-1:0]              i_host_wdata;
   logic [USIZE-1:0]              o_host_rdata;
`ifdef SHMEM_OOR_ERR_EN
   logic                          o_oor_err;
   logic [$clog2(NPROC)-1:0]      o_oor_id;
`endif

   always #5 i_clk = ~i_clk;

   shmem_arbiter #(
      .NPROC(NPROC), .USIZE(USIZE), .SIMD_W(SIMD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_addr(i_addr),
      .i_wr_data(i_wr_data), .i_wr_size(i_wr_size), .i_wr_en(i_wr_en),
      .o_grant_rd(o_grant_rd), .o_grant_wr(o_grant_wr), .o_rd_data(o_rd_data),
      .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
      .o_host_rdata(o_host_rdata)
`ifdef SHMEM_OOR_ERR_EN
      , .o_oor_err(o_oor_err), .o_oor_id(o_oor_id)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [USIZE-1:0] mdl_mem [DEPTH];
   int               m_owner = -1;
   int               m_ptr   = 0;
   bit               m_err   = 1'b0;
   int               m_id    = 0;

   task automatic check_eq(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_all();
      i_req_rd  = '0;
      i_req_wr  = '0;
      i_wr_en   = '0;
      i_host_we = 1'b0;
   endtask

   task automatic drive(input int p, input bit rd, input bit wr, input int addr,
                        input logic [BUS_W-1:0] data, input int size, input bit en);
      i_req_rd[p]                 = rd;
      i_req_wr[p]                 = wr;
      i_addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
      i_wr_data[p*BUS_W +: BUS_W] = data;
      i_wr_size[p*3 +: 3]         = 3'(size);
      i_wr_en[p]                  = en;
   endtask

   // One clock: check outputs against the model before the edge, then advance the model at the edge
   task automatic step();
      int               g;
      bit               is_rd;
      int               a0;
      int               sz;
      logic [NPROC-1:0] e_grd;
      logic [NPROC-1:0] e_gwr;
      logic [BUS_W-1:0] e_rd;
      @(negedge i_clk);
      g = -1;
      if (!i_host_we) begin
         if (m_owner >= 0) begin
            if (i_req_rd[m_owner] || i_req_wr[m_owner]) g = m_owner;
         end else begin
            for (int i = 0; i < NPROC; i++) begin
               int p;
               p = (m_ptr + i) % NPROC;
               if (g < 0 && (i_req_rd[p] || i_req_wr[p])) g = p;
            end
         end
      end
      is_rd = 1'b0;
      a0    = 0;
      e_grd = '0;
      e_gwr = '0;
      e_rd  = '0;
      if (g >= 0) begin
         is_rd = i_req_rd[g];
         a0    = int'(i_addr[g*ADDR_W +: ADDR_W]);
         if (is_rd) e_grd[g] = 1'b1;
         else       e_gwr[g] = 1'b1;
         if (is_rd) begin
            for (int k = 0; k < SIMD_W; k++)
               if (a0 + k < DEPTH) e_rd[BUS_W-1-k*USIZE -: USIZE] = mdl_mem[a0+k];
         end
      end
      check_eq("grant_rd", o_grant_rd, e_grd);
      check_eq("grant_wr", o_grant_wr, e_gwr);
      check_eq("rd_data", o_rd_data, e_rd);
      check_eq("host_rdata", o_host_rdata, mdl_mem[int'(i_host_addr)]);
`ifdef SHMEM_OOR_ERR_EN
      check_eq("oor_err", o_oor_err, m_err);
      check_eq("oor_id", o_oor_id, m_id);
`endif
      @(posedge i_clk);
      if (i_host_we) begin
         if (int'(i_host_addr) < DEPTH) mdl_mem[int'(i_host_addr)] = i_host_wdata;
      end else if (g >= 0) begin
         if (is_rd && (a0 + SIMD_W > DEPTH) && !m_err) begin
            m_err = 1'b1;
            m_id  = g;
         end
         if (!is_rd && i_wr_en[g]) begin
            sz = int'(i_wr_size[g*3 +: 3]);
            if (sz > SIMD_W) sz = SIMD_W;
            for (int k = 0; k < sz; k++)
               if (a0 + k < DEPTH) mdl_mem[a0+k] = i_wr_data[g*BUS_W + BUS_W-1-k*USIZE -: USIZE];
            if ((a0 + sz > DEPTH) && !m_err) begin
               m_err = 1'b1;
               m_id  = g;
            end
            m_owner = -1;
            m_ptr   = (g + 1) % NPROC;
         end else begin
            m_owner = g;
         end
      end else if (m_owner >= 0) begin
         m_ptr   = (m_owner + 1) % NPROC;
         m_owner = -1;
      end
      #1;
   endtask

   // Host readback of one element with a constant expectation (procs idle)
   task automatic readback(input string tag, input int addr, input logic [USIZE-1:0] exp);
      i_host_we   = 1'b0;
      i_host_addr = ADDR_W'(addr);
      #2;
      check_eq(tag, o_host_rdata, exp);
      step();
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_err   = 1'b0;
      m_id    = 0;
   endtask

   function automatic logic [BUS_W-1:0] rand_bus();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[BUS_W-1:0];
   endfunction

   initial begin
      logic [USIZE-1:0] keep;
      logic [NPROC-1:0] exp_oh;

      // Reset: grants stay low even with requests present
      i_rstn = 1'b0;
      clear_all();
      i_addr = '0; i_wr_data = '0; i_wr_size = '0;
      i_host_addr = '0; i_host_wdata = '0;
      i_req_rd = '1;
      #3;
      check_eq("rst_grant_rd", o_grant_rd, '0);
      check_eq("rst_grant_wr", o_grant_wr, '0);
      clear_all();
      @(posedge i_clk); @(posedge i_clk); #1;
      i_rstn = 1'b1;
      model_reset();

      // Preload the whole array through the host port
      for (int a = 0; a < DEPTH; a++) begin
         i_host_we    = 1'b1;
         i_host_addr  = ADDR_W'(a);
         i_host_wdata = (a < 5) ? USIZE'(a + 1) : USIZE'($urandom);
         step();
      end
      i_host_we = 1'b0;
      for (int a = 0; a < 5; a++) readback("preload", a, USIZE'(a + 1));

      // P0 bus read at 0, same-cycle grant and data
      drive(0, 1, 0, 0, '0, 0, 0);
      #2;
      check_eq("p0_rd_grant", o_grant_rd, 4'b0001);
      check_eq("p0_rd_data", o_rd_data, 80'h0001_0002_0003_0004_0005);
      step();
      clear_all();
      step();

      // Locked read, read, write by P0 while P1 keeps requesting
      drive(0, 1, 0, 0, '0, 0, 0);
      #2; check_eq("lock_a", o_grant_rd, 4'b0001);
      step();
      drive(0, 1, 0, 5, '0, 0, 0);
      drive(1, 1, 0, 200, '0, 0, 0);
      #2; check_eq("lock_b", o_grant_rd, 4'b0001);
      step();
      drive(0, 0, 1, 10, 80'h1111_2222_3333_4444_5555, 5, 1);
      #2; check_eq("lock_c_wr", o_grant_wr, 4'b0001);
      check_eq("lock_c_rd", o_grant_rd, 4'b0000);
      step();
      drive(0, 0, 0, 0, '0, 0, 0);
      #2; check_eq("lock_d_p1", o_grant_rd, 4'b0010);
      step();
      clear_all();
      step();
      for (int k = 0; k < 5; k++) readback("lock_wr_mem", 10 + k, USIZE'(16'h1111 * (k + 1)));

      // Round-robin fairness from a fresh reset: rd then wr per proc
      i_rstn = 1'b0;
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         int p;
         p      = i % NPROC;
         exp_oh = NPROC'(1) << p;
         clear_all();
         for (int q = 0; q < NPROC; q++) drive(q, 1, 0, 100 + q*8, '0, 0, 0);
         #2; check_eq("rr_rd", o_grant_rd, exp_oh);
         step();
         drive(p, 0, 1, 100 + p*8, rand_bus(), $urandom_range(0, 7), 1);
         #2; check_eq("rr_wr", o_grant_wr, exp_oh);
         step();
      end
      clear_all();
      step();

      // Partial write of three elements, then a size-0 write that still releases the lock
      keep = mdl_mem[23];
      drive(2, 0, 1, 20, 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 3, 1);
      step();
      clear_all();
      readback("part_20", 20, 16'hAAAA);
      readback("part_21", 21, 16'hBBBB);
      readback("part_22", 22, 16'hCCCC);
      readback("part_23", 23, keep);
      keep = mdl_mem[30];
      drive(2, 0, 1, 30, 80'h1234_1234_1234_1234_1234, 0, 1);
      #2; check_eq("size0_grant", o_grant_wr, 4'b0100);
      step();
      clear_all();
      drive(1, 1, 0, 40, '0, 0, 0);
      #2; check_eq("size0_release", o_grant_rd, 4'b0010);
      step();
      clear_all();
      step();
      readback("size0_mem", 30, keep);

      // Boundary read and write at the top of the array
      i_host_we = 1'b1; i_host_addr = 10'd1022; i_host_wdata = 16'h1234; step();
      i_host_we = 1'b1; i_host_addr = 10'd1023; i_host_wdata = 16'h5678; step();
      i_host_we = 1'b0;
      drive(1, 1, 0, 1022, '0, 0, 0);
      #2; check_eq("bnd_rd", o_rd_data, 80'h1234_5678_0000_0000_0000);
      step();
      drive(1, 0, 1, 1022, 80'h9999_8888_7777_6666_5555, 5, 1);
      #2; check_eq("bnd_wr_grant", o_grant_wr, 4'b0010);
      step();
      clear_all();
      step();
      readback("bnd_1022", 1022, 16'h9999);
      readback("bnd_1023", 1023, 16'h8888);
      readback("bnd_nowrap", 0, 16'h0001);
`ifdef SHMEM_OOR_ERR_EN
      check_eq("bnd_oor_err", o_oor_err, 1'b1);
      check_eq("bnd_oor_id", o_oor_id, 2'd1);
`endif

      // Host collision during P3's locked read, then reset in the middle of the lock
      drive(3, 1, 0, 40, '0, 0, 0);
      #2; check_eq("host_pre", o_grant_rd, 4'b1000);
      step();
      drive(0, 1, 0, 0, '0, 0, 0);
      i_host_we = 1'b1; i_host_addr = 10'd50; i_host_wdata = 16'hBEEF;
      #2; check_eq("host_sup_rd", o_grant_rd, 4'b0000);
      check_eq("host_sup_wr", o_grant_wr, 4'b0000);
      step();
      i_host_we = 1'b0;
      #2; check_eq("host_regrant", o_grant_rd, 4'b1000);
      check_eq("host_mem", o_host_rdata, 16'hBEEF);
      step();
      i_rstn = 1'b0;
      #2; check_eq("rst_mid_rd", o_grant_rd, 4'b0000);
      check_eq("rst_mid_wr", o_grant_wr, 4'b0000);
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      model_reset();
      for (int q = 0; q < NPROC; q++) drive(q, 1, 0, 300 + q, '0, 0, 0);
      #2; check_eq("rst_p0_first", o_grant_rd, 4'b0001);
      step();
      clear_all();
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < NPROC; p++) begin
            int r;
            int a;
            r = $urandom_range(0, 3);
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(1015, 1023);
            drive(p, (r == 1) || (r == 3), (r == 2) || (r == 3), a, rand_bus(),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         end
         i_host_we    = ($urandom_range(0, 9) == 0);
         i_host_addr  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 40))
                                                    : ADDR_W'($urandom_range(1015, 1023));
         i_host_wdata = USIZE'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
